// File: rtl/ram_pkg.sv
// Shared constants and FSM encoding for the RAM-backed FIFO controller and the RAM block.
package ram_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Streaming handshake bundle: producer-side input channel and consumer-side output channel.
interface ram_fifo_ctrl_if;
    import ram_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sharing one single-port RAM between enqueue writes and in-order reads
// into an output register; reads win the port in IDLE, writes are always offered in RD_WAIT.
module ram_fifo_ctrl
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    ram_fifo_ctrl_if.slave    s_if,
    output logic              ram_wrenable,
    output logic              ram_rdenable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              rd_issue_s;
    logic              wr_issue_s;
    logic              in_ready_s;
    logic              full_s;

    // Port arbitration, pointer/count update and output-register next state
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        rd_issue_s   = 1'b0;
        ram_address  = PTR_ZERO;
        ram_data_in  = {DATA_W{1'b0}};
        full_s       = (count_q == CNT_FULL);

        case (state_q)
            IDLE: begin
                if ((count_q != CNT_ZERO) && (!out_valid_q || s_if.out_ready)) begin
                    rd_issue_s = 1'b1;
                    state_d    = RD_WAIT;
                end else begin
                    state_d    = IDLE;
                end
            end
            RD_WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_s = !rd_issue_s && !full_s;
        wr_issue_s = s_if.in_valid && in_ready_s;

        if (rd_issue_s) begin
            ram_address = rd_ptr_q;
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            count_d     = count_q - CNT_ONE;
        end else if (wr_issue_s) begin
            ram_address = wr_ptr_q;
            ram_data_in = s_if.in_data;
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            count_d     = count_q + CNT_ONE;
        end else begin
            ram_address = PTR_ZERO;
        end

        // RAM data_out is valid in the cycle after the read edge, i.e. throughout RD_WAIT
        if (state_q == RD_WAIT) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_data_out;
        end else if (out_valid_q && s_if.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, pointer, count and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign ram_wrenable   = wr_issue_s;
    assign ram_rdenable   = rd_issue_s;
    assign s_if.in_ready  = in_ready_s;
    assign s_if.out_valid = out_valid_q;
    assign s_if.out_data  = out_data_q;
    assign count          = count_q;
    assign full           = full_s;
    assign empty          = (count_q == CNT_ZERO) && !out_valid_q && (state_q == IDLE);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural single-port RAM beside the DUT.
module tb_ram_fifo_ctrl;
    import ram_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              ram_wrenable;
    logic              ram_rdenable;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [DATA_W-1:0] tx_q [$];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_w;
    int                n_tests;
    int                n_fail;
    int                max_count;

    ram_fifo_ctrl_if bus();

    ram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_if         (bus),
        .ram_wrenable (ram_wrenable),
        .ram_rdenable (ram_rdenable),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: data_out only changes on a read edge
    always @(posedge clk) begin
        if (ram_wrenable) ram_mem[ram_address] <= ram_data_in;
        if (ram_rdenable) ram_data_out <= ram_mem[ram_address];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mode_on(input int mode, input int cyc, input int period);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return (cyc % period) != (period - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stop_mode: 0 = fixed cycles, 1 = until tx_q drained, 2 = until tx_q and exp_q drained
    task automatic run_stream(input int budget, input int in_mode, input int out_mode, input int stop_mode);
        bit                done;
        bit                in_acc;
        bit                out_acc;
        logic [DATA_W-1:0] got;
        done = 1'b0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            bus.in_valid  = (tx_q.size() > 0) && mode_on(in_mode, cyc, 3);
            bus.in_data   = (tx_q.size() > 0) ? tx_q[0] : {DATA_W{1'b0}};
            bus.out_ready = mode_on(out_mode, cyc, 4);
            #1;
            in_acc  = bus.in_valid && bus.in_ready;
            out_acc = bus.out_valid && bus.out_ready;
            got     = bus.out_data;
            if (int'(count) > max_count) max_count = int'(count);
            tick();
            if (in_acc) void'(tx_q.pop_front());
            if (out_acc) begin
                check_val("out_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_val("out_data", 32'(got), 32'(exp_q.pop_front()));
            end
            done = ((stop_mode == 1) && (tx_q.size() == 0)) ||
                   ((stop_mode == 2) && (tx_q.size() == 0) && (exp_q.size() == 0));
        end
        if (stop_mode != 0) check_val("stream_done", 32'(done), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = {DATA_W{1'b0}};
        bus.out_ready = 1'b0;
        tx_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        max_count = 0;
        rst_n     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = {DATA_W{1'b0}};
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_count",     32'(count),        32'd0);
        check_val("rst_full",      32'(full),         32'd0);
        check_val("rst_empty",     32'(empty),        32'd1);
        check_val("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_data",  32'(bus.out_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Empty-queue latency: write in N, out_valid in N+3
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hA5A5;
        #1;
        check_val("lat_n_in_ready", 32'(bus.in_ready),   32'd1);
        check_val("lat_n_wren",     32'(ram_wrenable),   32'd1);
        check_val("lat_n_addr",     32'(ram_address),    32'd0);
        check_val("lat_n_din",      32'(ram_data_in),    32'hA5A5);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check_val("lat_n1_rden",    32'(ram_rdenable),   32'd1);
        check_val("lat_n1_ovalid",  32'(bus.out_valid),  32'd0);
        tick();
        check_val("lat_n2_ovalid",  32'(bus.out_valid),  32'd0);
        check_val("lat_n2_rden",    32'(ram_rdenable),   32'd0);
        check_val("lat_n2_in_ready", 32'(bus.in_ready),  32'd1);
        tick();
        check_val("lat_n3_ovalid",  32'(bus.out_valid),  32'd1);
        check_val("lat_n3_odata",   32'(bus.out_data),   32'hA5A5);
        exp_q.push_back(16'hA5A5);
        run_stream(50, 1, 1, 2);

        // Five words under backpressure, then drained in order
        tx_q  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hFEDC};
        exp_q = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hFEDC};
        run_stream(100, 1, 0, 1);
        check_val("bp5_count",  32'(count),        32'd4);
        check_val("bp5_odata",  32'(bus.out_data), 32'h1234);
        run_stream(100, 0, 1, 2);
        check_val("bp5_empty",  32'(empty),        32'd1);
        check_val("bp5_count0", 32'(count),        32'd0);

        // Read takes priority in IDLE; the blocked write lands in RD_WAIT
        apply_reset();
        tx_q  = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
        exp_q = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0104};
        run_stream(100, 1, 0, 1);
        check_val("prio_count3", 32'(count), 32'd3);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0104;
        bus.out_ready = 1'b1;
        #1;
        check_val("prio_rden",     32'(ram_rdenable),  32'd1);
        check_val("prio_in_ready", 32'(bus.in_ready),  32'd0);
        check_val("prio_wren",     32'(ram_wrenable),  32'd0);
        check_val("prio_rd_addr",  32'(ram_address),   32'd1);
        exp_w = exp_q.pop_front();
        check_val("prio_odata",    32'(bus.out_data),  32'(exp_w));
        tick();
        check_val("prio_rw_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("prio_rw_wren",  32'(ram_wrenable),  32'd1);
        check_val("prio_rw_addr",  32'(ram_address),   32'd4);
        check_val("prio_rw_din",   32'(ram_data_in),   32'h0104);
        check_val("prio_rw_count", 32'(count),         32'd2);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_val("prio_after_count", 32'(count),      32'd3);
        run_stream(200, 0, 1, 2);

        // Fill to capacity: output register plus 32 words in RAM
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            tx_q.push_back(16'(i));
            exp_q.push_back(16'(i));
        end
        run_stream(500, 1, 0, 1);
        check_val("fill_count31", 32'(count),         32'd31);
        check_val("fill_ovalid",  32'(bus.out_valid), 32'd1);
        check_val("fill_odata",   32'(bus.out_data),  32'd0);
        check_val("fill_in_ready", 32'(bus.in_ready), 32'd1);
        tx_q.push_back(16'h0020);
        exp_q.push_back(16'h0020);
        run_stream(50, 1, 0, 1);
        check_val("full_count",    32'(count),        32'd32);
        check_val("full_flag",     32'(full),         32'd1);
        check_val("full_in_ready", 32'(bus.in_ready), 32'd0);
        tx_q.push_back(16'h0021);
        exp_q.push_back(16'h0021);
        run_stream(4, 1, 0, 0);
        check_val("full_hold_count", 32'(count),       32'd32);
        check_val("full_hold_pending", 32'(tx_q.size()), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check_val("full_rden",     32'(ram_rdenable), 32'd1);
        exp_w = exp_q.pop_front();
        check_val("full_odata",    32'(bus.out_data), 32'(exp_w));
        tick();
        bus.out_ready = 1'b0;
        #1;
        check_val("full_drop",     32'(full),         32'd0);
        check_val("full_drop_count", 32'(count),      32'd31);
        run_stream(1000, 1, 1, 2);

        // Interleaved traffic across the pointer wrap
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            tx_q.push_back(16'hC000 + 16'(i * 7));
            exp_q.push_back(16'hC000 + 16'(i * 7));
        end
        run_stream(3000, 2, 2, 2);
        check_val("wrap_count_le_depth", 32'(max_count <= DEPTH), 32'd1);
        check_val("wrap_empty", 32'(empty), 32'd1);

        // Reset during RD_WAIT abandons the read
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7777;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_val("rstrw_ovalid", 32'(bus.out_valid), 32'd0);
        check_val("rstrw_count",  32'(count),         32'd0);
        check_val("rstrw_empty",  32'(empty),         32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check_val("rstrw_post_ovalid", 32'(bus.out_valid), 32'd0);
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(16'h0F0F);
        exp_q.push_back(16'h0F0F);
        run_stream(50, 1, 1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
